// File: rtl/gpu_block_scheduler_if.sv
// rtl/gpu_block_scheduler_if.sv - scheduler to compute-core handshake bundle
interface gpu_block_scheduler_if #(
    parameter int NUM_CORES     = 2,
    parameter int BLOCK_ID_BITS = 8,
    parameter int CORE_TC_BITS  = 3
);
    logic [NUM_CORES-1:0]               core_reset;
    logic [NUM_CORES-1:0]               core_start;
    logic [NUM_CORES-1:0]               core_done;
    logic [NUM_CORES*BLOCK_ID_BITS-1:0] core_block_id;
    logic [NUM_CORES*CORE_TC_BITS-1:0]  core_thread_count;

    modport master (
        output core_reset,
        output core_start,
        output core_block_id,
        output core_thread_count,
        input  core_done
    );

    modport slave (
        input  core_reset,
        input  core_start,
        input  core_block_id,
        input  core_thread_count,
        output core_done
    );
endinterface

// File: rtl/gpu_block_scheduler.sv
// rtl/gpu_block_scheduler.sv - splits a kernel launch into blocks and dispatches them to free cores
module gpu_block_scheduler #(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_COUNT_BITS = 8,
    parameter int BLOCK_ID_BITS     = 8,
    parameter int CYCLE_COUNT_BITS  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [THREAD_COUNT_BITS-1:0] thread_count,
    input  logic [NUM_CORES-1:0]         core_enable_mask,
    input  logic                         abort,
    gpu_block_scheduler_if.master        cores,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [BLOCK_ID_BITS:0]       blocks_dispatched,
    output logic [CYCLE_COUNT_BITS-1:0]  cycle_count
);
    localparam int TPB_LOG2 = $clog2(THREADS_PER_BLOCK);
    localparam int TCW      = TPB_LOG2 + 1;
    localparam int CNT_BITS = BLOCK_ID_BITS + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
    typedef enum logic [1:0] {SLOT_FREE, SLOT_ASSIGN, SLOT_ACTIVE} slot_e;

    state_e                                 state_q;
    slot_e                                  slot_q [NUM_CORES];
    logic [NUM_CORES-1:0]                   mask_q;
    logic [CNT_BITS-1:0]                    total_q;
    logic [CNT_BITS-1:0]                    completed_q;
    logic [TPB_LOG2-1:0]                    tc_low_q;
    logic [NUM_CORES-1:0]                   core_reset_q;
    logic [NUM_CORES-1:0]                   core_start_q;
    logic [NUM_CORES-1:0][BLOCK_ID_BITS-1:0] block_id_q;
    logic [NUM_CORES-1:0][TCW-1:0]          block_tc_q;

    logic [NUM_CORES-1:0]     alloc;
    logic [NUM_CORES-1:0]     done_hit;
    logic [BLOCK_ID_BITS-1:0] alloc_id [NUM_CORES];
    logic [TCW-1:0]           alloc_tc [NUM_CORES];
    logic [CNT_BITS-1:0]      id_next;
    logic [CNT_BITS-1:0]      n_done;
    logic [CNT_BITS-1:0]      completed_next;
    logic [CNT_BITS-1:0]      total_calc;

    assign total_calc = CNT_BITS'(thread_count >> TPB_LOG2)
                      + CNT_BITS'(|thread_count[TPB_LOG2-1:0]);

    // Ids are handed out in core-index order so the lowest free core gets the lowest id.
    always_comb begin
        alloc    = '0;
        done_hit = '0;
        n_done   = '0;
        id_next  = blocks_dispatched;
        for (int i = 0; i < NUM_CORES; i++) begin
            alloc_id[i] = '0;
            alloc_tc[i] = '0;
            if (slot_q[i] == SLOT_ACTIVE && cores.core_done[i]) begin
                done_hit[i] = 1'b1;
                n_done      = n_done + CNT_BITS'(1);
            end
            if (state_q == S_RUN && !abort && slot_q[i] == SLOT_FREE && mask_q[i]
                && id_next < total_q) begin
                alloc[i]    = 1'b1;
                alloc_id[i] = id_next[BLOCK_ID_BITS-1:0];
                if (id_next == total_q - CNT_BITS'(1) && tc_low_q != '0)
                    alloc_tc[i] = {1'b0, tc_low_q};
                else
                    alloc_tc[i] = TCW'(THREADS_PER_BLOCK);
                id_next = id_next + CNT_BITS'(1);
            end
        end
        completed_next = completed_q + n_done;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_IDLE;
            for (int i = 0; i < NUM_CORES; i++) slot_q[i] <= SLOT_FREE;
            mask_q            <= '0;
            total_q           <= '0;
            completed_q       <= '0;
            tc_low_q          <= '0;
            core_reset_q      <= '1;
            core_start_q      <= '0;
            block_id_q        <= '0;
            block_tc_q        <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
            blocks_dispatched <= '0;
            cycle_count       <= '0;
        end else begin
            core_reset_q <= '0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q           <= S_RUN;
                        busy              <= 1'b1;
                        done              <= 1'b0;
                        error             <= 1'b0;
                        mask_q            <= core_enable_mask;
                        total_q           <= total_calc;
                        tc_low_q          <= thread_count[TPB_LOG2-1:0];
                        completed_q       <= '0;
                        blocks_dispatched <= '0;
                        cycle_count       <= '0;
                    end
                end
                S_RUN: begin
                    if (cycle_count != '1)
                        cycle_count <= cycle_count + CYCLE_COUNT_BITS'(1);
                    if (abort) begin
                        // A simultaneous core_done is dropped: the kernel is dead either way.
                        state_q      <= S_DONE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        error        <= 1'b1;
                        core_reset_q <= mask_q;
                        core_start_q <= '0;
                        for (int i = 0; i < NUM_CORES; i++) slot_q[i] <= SLOT_FREE;
                    end else begin
                        for (int i = 0; i < NUM_CORES; i++) begin
                            case (slot_q[i])
                                SLOT_FREE: begin
                                    if (alloc[i]) begin
                                        slot_q[i]       <= SLOT_ASSIGN;
                                        core_reset_q[i] <= 1'b1;
                                        block_id_q[i]   <= alloc_id[i];
                                        block_tc_q[i]   <= alloc_tc[i];
                                    end
                                end
                                SLOT_ASSIGN: begin
                                    slot_q[i]       <= SLOT_ACTIVE;
                                    core_start_q[i] <= 1'b1;
                                end
                                SLOT_ACTIVE: begin
                                    if (done_hit[i]) begin
                                        slot_q[i]       <= SLOT_FREE;
                                        core_start_q[i] <= 1'b0;
                                    end
                                end
                                default: slot_q[i] <= SLOT_FREE;
                            endcase
                        end
                        blocks_dispatched <= id_next;
                        completed_q       <= completed_next;
                        if (completed_next == total_q) begin
                            state_q <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else if (mask_q == '0) begin
                            state_q <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            error   <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cores.core_reset        = core_reset_q;
    assign cores.core_start        = core_start_q;
    assign cores.core_block_id     = block_id_q;
    assign cores.core_thread_count = block_tc_q;
endmodule

// File: tb/tb_gpu_block_scheduler.sv
// tb/tb_gpu_block_scheduler.sv - self-checking bench for gpu_block_scheduler
module tb_gpu_block_scheduler;
    localparam int NC   = 2;
    localparam int TPB  = 4;
    localparam int TCB  = 8;
    localparam int BIDB = 8;
    localparam int CCB  = 32;
    localparam int CTB  = 3;

    typedef struct { int cyc; int core; int id; int tc; } ev_t;
    typedef struct { int tc; int mask; int lat; int blocks; int err; int cycles; } vec_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [TCB-1:0]  thread_count = '0;
    logic [NC-1:0]   core_enable_mask = '0;
    logic [NC-1:0]   auto_done = '0;
    logic [NC-1:0]   man_done = '0;
    logic [NC-1:0]   cur_mask = '0;
    logic            auto_en = 1'b1;
    logic            busy, done, error;
    logic [BIDB:0]   blocks_dispatched;
    logic [CCB-1:0]  cycle_count;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   start_seen = 0;
    int   masked_hits = 0;
    int   lat_tab [256];
    int   rcnt [NC];
    ev_t  mev;
    ev_t  log_q [$];
    ev_t  exp_q [$];
    vec_t vecs [8];

    gpu_block_scheduler_if #(.NUM_CORES(NC), .BLOCK_ID_BITS(BIDB), .CORE_TC_BITS(CTB)) cif ();
    assign cif.core_done = auto_done | man_done;

    gpu_block_scheduler #(
        .NUM_CORES(NC), .THREADS_PER_BLOCK(TPB), .THREAD_COUNT_BITS(TCB),
        .BLOCK_ID_BITS(BIDB), .CYCLE_COUNT_BITS(CCB)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
        .core_enable_mask(core_enable_mask), .abort(abort), .cores(cif),
        .busy(busy), .done(done), .error(error),
        .blocks_dispatched(blocks_dispatched), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Dispatch logger plus a behavioural core that answers each block after lat_tab[id] cycles.
    initial begin
        for (int i = 0; i < NC; i++) rcnt[i] = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (busy && !reset) begin
                for (int i = 0; i < NC; i++) begin
                    if (cif.core_reset[i]) begin
                        mev.cyc  = cyc;
                        mev.core = i;
                        mev.id   = int'(cif.core_block_id[i*BIDB +: BIDB]);
                        mev.tc   = int'(cif.core_thread_count[i*CTB +: CTB]);
                        log_q.push_back(mev);
                    end
                    if (!cur_mask[i] && (cif.core_reset[i] || cif.core_start[i])) masked_hits++;
                end
            end
            if (|cif.core_start) start_seen++;
            for (int i = 0; i < NC; i++) begin
                if (!auto_en || auto_done[i]) begin
                    auto_done[i] = 1'b0;
                    rcnt[i] = 0;
                end else if (cif.core_start[i]) begin
                    rcnt[i]++;
                    if (rcnt[i] >= lat_tab[cif.core_block_id[i*BIDB +: BIDB]]) auto_done[i] = 1'b1;
                end else begin
                    rcnt[i] = 0;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Greedy list schedule: each block in id order goes to the enabled core that frees up first.
    task automatic build_model(input int tc, input int mask, input int t,
                               output int e_end, output int nblk, output int err);
        int   free_at [NC];
        ev_t  ev;
        exp_q.delete();
        nblk  = 0;
        err   = 0;
        e_end = t + 1;
        if (tc == 0) return;
        if (mask == 0) begin
            err = 1;
            return;
        end
        nblk = (tc + TPB - 1) / TPB;
        for (int c = 0; c < NC; c++) free_at[c] = t + 1;
        for (int b = 0; b < nblk; b++) begin
            int best;
            best = -1;
            for (int c = 0; c < NC; c++)
                if (mask[c] && (best < 0 || free_at[c] < free_at[best])) best = c;
            ev.cyc  = free_at[best];
            ev.core = best;
            ev.id   = b;
            ev.tc   = (tc - b * TPB < TPB) ? tc - b * TPB : TPB;
            exp_q.push_back(ev);
            if (free_at[best] + lat_tab[b] + 1 > e_end) e_end = free_at[best] + lat_tab[b] + 1;
            free_at[best] += lat_tab[b] + 2;
        end
    endtask

    task automatic run_kernel(input int tc, input int mask, input bit poke,
                              output int got_blocks, output int got_err, output int got_cycles);
        int t, e_end, nblk, err, base, s0, m0, k;
        thread_count     = tc[TCB-1:0];
        core_enable_mask = mask[NC-1:0];
        cur_mask         = mask[NC-1:0];
        start            = 1'b1;
        t                = cyc + 1;
        build_model(tc, mask, t, e_end, nblk, err);
        base = log_q.size();
        s0   = start_seen;
        m0   = masked_hits;
        tick();
        start = 1'b0;
        check("launch_busy", busy, 1);
        check("launch_done", done, 0);
        k = 0;
        while (!done && k < 4000) begin
            if (poke && k == 2) start = 1'b1;
            if (k == 3) start = 1'b0;
            tick();
            k++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        check("done_edge", cyc, e_end);
        check("busy_end", busy, 0);
        check("cycle_count", cycle_count, e_end - t);
        check("blocks_dispatched", blocks_dispatched, nblk);
        check("error", error, err);
        got_blocks = int'(blocks_dispatched);
        got_err    = int'(error);
        got_cycles = int'(cycle_count);
        tick();
        check("done_hold", done, 1);
        check("dispatch_len", log_q.size() - base, exp_q.size());
        for (int j = 0; j < exp_q.size() && base + j < log_q.size(); j++) begin
            check("disp_cyc", log_q[base+j].cyc, exp_q[j].cyc);
            check("disp_core", log_q[base+j].core, exp_q[j].core);
            check("disp_id", log_q[base+j].id, exp_q[j].id);
            check("disp_tc", log_q[base+j].tc, exp_q[j].tc);
        end
        check("masked_core_quiet", masked_hits - m0, 0);
        if (nblk == 0) check("no_core_start", start_seen - s0, 0);
    endtask

    initial begin
        int gb, ge, gc, tc, mask;
        for (int j = 0; j < 256; j++) lat_tab[j] = 5;

        vecs[0] = '{8,   3, 5, 2,  0, 7};
        vecs[1] = '{13,  3, 5, 4,  0, 14};
        vecs[2] = '{8,   2, 5, 2,  0, 14};
        vecs[3] = '{0,   3, 5, 0,  0, 1};
        vecs[4] = '{8,   0, 5, 0,  1, 1};
        vecs[5] = '{1,   3, 1, 1,  0, 3};
        vecs[6] = '{9,   1, 2, 3,  0, 12};
        vecs[7] = '{255, 3, 5, 64, 0, 224};

        reset = 1'b1;
        tick();
        tick();
        check("rst_core_reset", cif.core_reset, 2'b11);
        check("rst_core_start", cif.core_start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_blocks", blocks_dispatched, 0);
        check("rst_cycles", cycle_count, 0);
        check("rst_block_id", cif.core_block_id, 0);
        check("rst_thread_count", cif.core_thread_count, 0);
        reset = 1'b0;
        tick();
        check("rel_core_reset", cif.core_reset, 0);

        for (int v = 0; v < 8; v++) begin
            for (int j = 0; j < 256; j++) lat_tab[j] = vecs[v].lat;
            run_kernel(vecs[v].tc, vecs[v].mask, vecs[v].blocks >= 3, gb, ge, gc);
            check("vec_blocks", gb, vecs[v].blocks);
            check("vec_error", ge, vecs[v].err);
            check("vec_cycles", gc, vecs[v].cycles);
        end

        // core_done while the slot is still in its reset cycle must be ignored
        auto_en = 1'b0;
        thread_count = 8; core_enable_mask = 2'b11; cur_mask = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("early_reset", cif.core_reset, 2'b11);
        man_done = 2'b11;
        tick();
        man_done = 2'b00;
        check("early_start", cif.core_start, 2'b11);
        check("early_busy", busy, 1);
        tick();
        check("early_start_held", cif.core_start, 2'b11);
        check("early_not_done", done, 0);
        man_done = 2'b11;
        tick();
        man_done = 2'b00;
        check("early_done", done, 1);
        check("early_busy_end", busy, 0);
        check("early_start_drop", cif.core_start, 0);
        check("early_cycles", cycle_count, 4);
        check("early_blocks", blocks_dispatched, 2);
        check("early_error", error, 0);

        // abort together with core_done
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("ab_start", cif.core_start, 2'b11);
        tick();
        tick();
        abort = 1'b1;
        man_done = 2'b11;
        tick();
        abort = 1'b0;
        man_done = 2'b00;
        check("ab_start_drop", cif.core_start, 0);
        check("ab_reset_pulse", cif.core_reset, 2'b11);
        check("ab_done", done, 1);
        check("ab_error", error, 1);
        check("ab_busy", busy, 0);
        check("ab_blocks", blocks_dispatched, 2);
        tick();
        check("ab_reset_end", cif.core_reset, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_idle_reset", cif.core_reset, 0);
        check("ab_idle_done", done, 1);
        check("ab_idle_error", error, 1);
        auto_en = 1'b1;

        // reset in the middle of a kernel, then relaunch
        for (int j = 0; j < 256; j++) lat_tab[j] = 5;
        thread_count = 40; core_enable_mask = 2'b11; cur_mask = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 8; j++) tick();
        check("mid_busy", busy, 1);
        reset = 1'b1;
        tick();
        check("mid_rst_core_reset", cif.core_reset, 2'b11);
        check("mid_rst_start", cif.core_start, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_blocks", blocks_dispatched, 0);
        check("mid_rst_cycles", cycle_count, 0);
        check("mid_rst_id", cif.core_block_id, 0);
        reset = 1'b0;
        tick();
        check("mid_rel_core_reset", cif.core_reset, 0);
        run_kernel(4, 3, 1'b0, gb, ge, gc);
        check("relaunch_cycles", gc, 7);
        check("relaunch_blocks", gb, 1);

        for (int r = 0; r < 30; r++) begin
            for (int j = 0; j < 256; j++) lat_tab[j] = $urandom_range(1, 6);
            tc   = $urandom_range(0, 64);
            mask = $urandom_range(0, 3);
            run_kernel(tc, mask, (tc > 8) && (mask != 0) && ($urandom_range(0, 1) == 1), gb, ge, gc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gpu_block_scheduler.md
# gpu_block_scheduler

Parametrised kernel block scheduler for the GPU top level, the successor to the fixed dispatcher. It latches a kernel launch (thread count plus per-core enable mask), splits it into blocks of THREADS_PER_BLOCK threads, and hands blocks to free compute cores through a reset/start/done handshake. It adds three things the previous dispatcher lacked: a core enable mask, a mid-kernel abort, and kernel cycle/block counters. It sits between the device control register and the compute cores.

## Interface
- NUM_CORES, 2, number of compute cores served
- THREADS_PER_BLOCK, 4, threads per block (power of two, ≥2)
- THREAD_COUNT_BITS, 8, width of kernel thread count
- BLOCK_ID_BITS, 8, width of block id (≥ THREAD_COUNT_BITS − log2(THREADS_PER_BLOCK))
- CYCLE_COUNT_BITS, 32, width of kernel cycle counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  launch request, sampled only in IDLE/DONE
- thread_count  in  THREAD_COUNT_BITS  kernel thread count, sampled at launch
- core_enable_mask  in  NUM_CORES  cores usable by this kernel, sampled at launch
- abort  in  1  kill running kernel
- core_done  in  NUM_CORES  per-core block completion
- core_reset  out  NUM_CORES  per-core reset pulse
- core_start  out  NUM_CORES  per-core start, held until done
- core_block_id  out  NUM_CORES×BLOCK_ID_BITS  block assigned to each core
- core_thread_count  out  NUM_CORES×(log2(THREADS_PER_BLOCK)+1)  live threads in assigned block
- busy  out  1  kernel running
- done  out  1  kernel finished (normally or aborted)
- error  out  1  last kernel aborted or had an empty mask
- blocks_dispatched  out  BLOCK_ID_BITS+1  blocks issued this kernel
- cycle_count  out  CYCLE_COUNT_BITS  cycles spent in RUN this kernel

## Operation
- Top FSM: IDLE → RUN on start; RUN → DONE when completed == total_blocks, on abort, or on empty mask; DONE → RUN on start. start in RUN is ignored.
- total_blocks = ceil(thread_count / THREADS_PER_BLOCK), latched at launch with the mask. Launch clears blocks_dispatched, the completion count, cycle_count, done and error.
- Per-core slot FSM: FREE → ASSIGN (1 cycle, core_reset=1, block_id/thread_count loaded) → ACTIVE (core_start=1) → FREE once core_done is sampled high.
- Allocation: each cycle in RUN, every FREE and enabled slot takes the next block while blocks remain. Several slots can be assigned in the same cycle. The lowest core index gets the lowest block id.
- core_thread_count = THREADS_PER_BLOCK for full blocks. For the last block it is thread_count − id×THREADS_PER_BLOCK when that is nonzero.
- thread_count == 0: RUN → DONE after one cycle, no core_start, error=0.
- Mask all zero with thread_count > 0: DONE after one cycle, error=1, no dispatch.
- Abort in RUN: all core_start drop next cycle, core_reset pulses 1 cycle on every enabled core, state → DONE, error=1.
- Abort and core_done in the same cycle: abort wins and the completion is not counted. abort outside RUN is ignored.
- core_done on a slot that is not ACTIVE is ignored.
- cycle_count increments every RUN cycle, saturates at all-ones, and freezes in DONE.

## Timing
- Reset (any time, including mid-kernel): state IDLE, all slots FREE, core_reset = all ones while reset is high. Every other output is 0.
- Cycle after reset release: core_reset = 0.
- Launch sampled at edge T: after T, busy=1 and done=0.
- After T+1: core_reset=1 on assigned cores.
- After T+2: core_start=1.
- core_done high at edge E: after E, core_start=0 and the completion is counted. A re-assignment of that core can fire at E+1.
- Final completion at edge E: after E, done=1 and busy=0. done holds until the next launch or reset.
- blocks_dispatched increments at the edge where core_reset is asserted.

## Test plan
- Basic run: NUM_CORES=2, TPB=4, thread_count=8, mask=2'b11. Cores 0/1 get ids 0/1 with thread_count 4. Each core_done is returned 5 cycles after its core_start. Expect done=1, blocks_dispatched=2, error=0.
- Partial block and reuse: thread_count=13, mask=2'b11. Expect ids 0..3 issued, with the last block at core_thread_count=1. Cores must be reused after their done, and blocks_dispatched=4.
- Masked core: thread_count=8, mask=2'b10. Expect core 0 to never see core_reset or core_start. Core 1 runs ids 0 then 1.
- Empty cases: thread_count=0 gives done after 1 cycle with error=0. mask=0 with thread_count=8 gives done with error=1. No core_start in either case.
- Abort: abort 3 cycles after core_start with core_done also high that cycle. Expect core_start=0 and a 1-cycle core_reset on both cores. Expect done=1, error=1, and the completion not counted.
- Reset mid-kernel: reset during RUN. Expect all outputs 0 except core_reset = all ones. A relaunch with thread_count=4 then completes normally with cycle_count restarted from 0.
